// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//
// Contents:
//   - datapath widths
//   - operation encodings carried on the 4-bit Op bus
//   - multiply and divide latencies, in cycles of Busy
//   - controller state encoding
//   - a helper that turns a latency into the down-counter load value
package muldiv_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  // Codes 6..9 exist only when the accumulate build option is on.
  // Otherwise they decode exactly like the unused codes 10..15.
  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The counter runs from lat-1 down to 0, so Busy lasts exactly lat cycles.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the E-stage issue logic and the
// multiply/divide unit.
//
// Signals:
//   Start  : operation valid this cycle (driven by master)
//   Cancel : M-stage flush; suppresses Start (driven by master)
//   Op     : operation code, see muldiv_unit_pkg::op_e (driven by master)
//   A      : rs operand (driven by master)
//   B      : rt operand (driven by master)
//   Busy   : operation in flight (driven by slave)
//   HI     : HI register (driven by slave)
//   LO     : LO register (driven by slave)
//   Done   : one-cycle commit pulse (driven by slave)
//
// Modports:
//   master : pipeline side
//   slave  : the unit
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
();

  logic              Start;
  logic              Cancel;
  logic [OP_W-1:0]   Op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              Busy;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic              Done;

  modport master (
    output Start, Cancel, Op, A, B,
    input  Busy, HI, LO, Done
  );

  modport slave (
    input  Start, Cancel, Op, A, B,
    output Busy, HI, LO, Done
  );

endinterface

// File: rtl/muldiv_divider.sv
// Combinational 32-bit divider for the multiply/divide unit.
//
// Ports:
//   sgn_i      : 1 = signed divide (DIV), 0 = unsigned divide (DIVU)
//   dividend_i : dividend
//   divisor_i  : divisor
//   quo_o      : quotient
//   rem_o      : remainder
//
// Behaviour:
//   - Signed results truncate toward zero.
//   - The remainder carries the sign of the dividend.
//   - Divide by zero returns an all-ones quotient and the dividend as remainder.
//   - The signed overflow case 0x80000000 / -1 returns 0x80000000 with a zero
//     remainder.
module muldiv_divider
  import muldiv_unit_pkg::*;
(
  input  logic              sgn_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] sdividend;
  logic signed [DATA_W-1:0] sdivisor;

  assign sdividend = dividend_i;
  assign sdivisor  = divisor_i;

  always_comb begin
    // Defaults are the divide-by-zero answer.
    quo_o = '1;
    rem_o = dividend_i;
    if (divisor_i != '0) begin
      if (sgn_i) begin
        // The true quotient +2^31 is not representable, so this case is
        // steered away from the signed divide operator.
        if (dividend_i == INT_MIN && divisor_i == '1) begin
          quo_o = INT_MIN;
          rem_o = '0;
        end else begin
          quo_o = sdividend / sdivisor;
          rem_o = sdividend % sdivisor;
        end
      end else begin
        quo_o = dividend_i / divisor_i;
        rem_o = dividend_i % divisor_i;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit.
//
// Operation:
//   - Accepts one operation from the E stage when idle.
//   - Runs it for a fixed latency (MUL_LAT or DIV_LAT).
//   - Commits the result to HI/LO on the final RUN edge.
//   - MTHI/MTLO write HI/LO directly on the accepting edge, without entering RUN.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if.slave (Start, Cancel, Op, A, B -> Busy, HI, LO, Done)
//
// Build option:
//   MULDIV_MADD_EN : when defined, MADD/MADDU/MSUB/MSUBU accumulate the product
//                    into {HI,LO}. When undefined, those codes are ignored and
//                    no accumulate adder exists.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = lat_to_cnt(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = lat_to_cnt(DIV_LAT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  op_e                 op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                load;
  op_e                 op_in;

  logic                mul_sgn;
  logic                div_sgn;
  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0]   quo, rem;

  assign op_in = op_e'(bus.Op);

  // Multiply datapath: extend both operands to 64 bits (sign or zero) so that
  // a single 64-bit multiply yields the exact product in its low half.
  assign mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign a_ext   = {{DATA_W{mul_sgn & a_q[DATA_W-1]}}, a_q};
  assign b_ext   = {{DATA_W{mul_sgn & b_q[DATA_W-1]}}, b_q};
  assign prod    = a_ext * b_ext;

`ifdef MULDIV_MADD_EN
  // Accumulate uses HI/LO as they stand at commit time, wrapping modulo 2^64.
  always_comb begin
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:           mul_res = prod;
    endcase
  end
`else
  assign mul_res = prod;
`endif

  assign div_sgn = (op_q == OP_DIV);

  muldiv_divider u_div (
    .sgn_i      (div_sgn),
    .dividend_i (a_q),
    .divisor_i  (b_q),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  // Next-state / commit logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start && !bus.Cancel) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              load    = 1'b1;
              cnt_d   = MUL_CNT;
              state_d = ST_RUN;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              load    = 1'b1;
              cnt_d   = MUL_CNT;
              state_d = ST_RUN;
            end
`endif
            OP_DIV, OP_DIVU: begin
              load    = 1'b1;
              cnt_d   = DIV_CNT;
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Start and Cancel are not looked at here: a launched operation
        // always runs to completion.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (op_q == OP_DIV || op_q == OP_DIVU) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand capture (accepting edge only)
  always_ff @(posedge clk) begin
    if (load) begin
      op_q <= op_in;
      a_q  <= bus.A;
      b_q  <= bus.B;
    end
  end

  // Done is decoded from registered state alone, so it is high during the
  // last RUN cycle, and HI/LO update on the edge that ends that cycle.
  assign bus.Busy = (state_q == ST_RUN);
  assign bus.Done = (state_q == ST_RUN) && (cnt_q == '0);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit op_ok(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: return 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic int op_lat(input logic [3:0] op);
    if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
    if (op == OP_MTHI || op == OP_MTLO) return 0;
    return MUL_LAT;
  endfunction

  // Reference result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    sp = longint'(signed'(a)) * longint'(signed'(b));
    up = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return {hi, lo} + sp;
      OP_MADDU: return {hi, lo} + up;
      OP_MSUB:  return {hi, lo} - sp;
      OP_MSUBU: return {hi, lo} - up;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Issue one operation and follow it to completion, checking every cycle.
  // While the unit is running, the inputs are driven with noise (including
  // Start with arbitrary ops) that must have no effect.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    int          lat;
    logic [63:0] res;
    bus.Start  = 1'b1;
    bus.Cancel = cancel;
    bus.Op     = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clk); #1;
    bus.Start  = 1'b0;
    bus.Cancel = 1'b0;
    if (cancel || !op_ok(op)) begin
      check("ignored_busy", bus.Busy, 1'b0);
      check("ignored_done", bus.Done, 1'b0);
      check("ignored_hilo", {bus.HI, bus.LO}, {exp_hi, exp_lo});
      return;
    end
    lat = op_lat(op);
    if (lat == 0) begin
      if (op == OP_MTHI) exp_hi = a;
      else               exp_lo = a;
      check("move_busy", bus.Busy, 1'b0);
      check("move_done", bus.Done, 1'b0);
      check("move_hilo", {bus.HI, bus.LO}, {exp_hi, exp_lo});
      return;
    end
    res = model(op, a, b, exp_hi, exp_lo);
    for (int k = 1; k <= lat; k++) begin
      check("run_busy", bus.Busy, 1'b1);
      check("run_done", bus.Done, (k == lat));
      check("run_hilo", {bus.HI, bus.LO}, {exp_hi, exp_lo});
      bus.Start  = 1'($urandom_range(0, 1));
      bus.Cancel = 1'($urandom_range(0, 1));
      bus.Op     = 4'($urandom_range(0, 15));
      bus.A      = $urandom;
      bus.B      = $urandom;
      @(posedge clk); #1;
      bus.Start  = 1'b0;
      bus.Cancel = 1'b0;
    end
    {exp_hi, exp_lo} = res;
    check("commit_busy", bus.Busy, 1'b0);
    check("commit_done", bus.Done, 1'b0);
    check($sformatf("commit_op%0d", op), {bus.HI, bus.LO}, {exp_hi, exp_lo});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    n_checks   = 0;
    n_errors   = 0;
    exp_hi     = '0;
    exp_lo     = '0;
    bus.Start  = 1'b0;
    bus.Cancel = 1'b0;
    bus.Op     = '0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.Busy, 1'b0);
    check("reset_done", bus.Done, 1'b0);
    check("reset_hilo", {bus.HI, bus.LO}, 64'h0);
    rst_n = 1'b1;

    // Directed cases
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_m2x3", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFA);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", {bus.HI, bus.LO}, {32'd2, 32'd14});
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_m7_2", {bus.HI, bus.LO}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(OP_DIV, 32'd5, 32'd0, 1'b0);
    check("div_by_zero", {bus.HI, bus.LO}, {32'd5, 32'hFFFFFFFF});
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf", {bus.HI, bus.LO}, {32'h0, 32'h80000000});
    issue(OP_MULT, 32'd9, 32'd9, 1'b1);
    check("cancel_keeps", {bus.HI, bus.LO}, {32'h0, 32'h80000000});
    issue(OP_MTLO, 32'h1234, 32'h0, 1'b0);
    check("mtlo", bus.LO, 32'h1234);
    issue(OP_MTHI, 32'h5678, 32'h0, 1'b0);
    check("mthi", {bus.HI, bus.LO}, {32'h5678, 32'h1234});
    issue(4'd6, 32'd2, 32'd3, 1'b0);
    issue(4'd15, 32'd2, 32'd3, 1'b0);

    // Reset in the middle of a divide
    bus.Start = 1'b1; bus.Cancel = 1'b0; bus.Op = OP_DIV;
    bus.A = 32'd1000; bus.B = 32'd3;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_busy", bus.Busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.Busy, 1'b0);
    check("midrst_done", bus.Done, 1'b0);
    check("midrst_hilo", {bus.HI, bus.LO}, 64'h0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_MULTU, 32'd3, 32'd4, 1'b0);
    check("multu_after_rst", {bus.HI, bus.LO}, {32'd0, 32'd12});

    // Random operations against the model
    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
            ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
